// File: rtl/ring_stop_arb.sv
// Ring-stop output arbiter: pops the ring-ingress and local-inject FIFO heads,
// ejects flits addressed to this node and sends the rest onto a credit-controlled link.
module ring_stop_arb #(
    parameter int WIDTH      = 8,
    parameter int ID_W       = 2,
    parameter int NODE_ID    = 0,
    parameter int CREDITS    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             iRingEmpty,
    input  logic [WIDTH-1:0]                 iRingDat,
    output logic                             oRingRdEn,
    input  logic                             iLocEmpty,
    input  logic [WIDTH-1:0]                 iLocDat,
    output logic                             oLocRdEn,
    output logic                             oLinkVld,
    output logic [WIDTH-1:0]                 oLinkDat,
    input  logic                             iLinkCrdt,
    output logic                             oEjVld,
    output logic [WIDTH-1:0]                 oEjDat,
    input  logic                             iEjRdy,
    output logic [$clog2(CREDITS+1)-1:0]     oCrdt,
    output logic                             oCrdtErr
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [ID_W-1:0] NODE      = ID_W'(NODE_ID);
    localparam logic [CW-1:0]   CRDT_MAX  = CW'(CREDITS);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    logic             link_vld_q, link_vld_d;
    logic [WIDTH-1:0] link_dat_q, link_dat_d;
    logic             ej_vld_q,   ej_vld_d;
    logic [WIDTH-1:0] ej_dat_q,   ej_dat_d;
    logic [CW-1:0]    crdt_q,     crdt_d;
    logic             crdt_err_q, crdt_err_d;
    logic [SW-1:0]    starve_q,   starve_d;

    logic ring_ej, ring_lk, loc_ej, loc_lk;
    logic ej_free, crdt_ok, starved;
    logic ring_ej_gnt, loc_ej_gnt, ring_lk_gnt, loc_lk_gnt, link_gnt;

    always_comb begin
        ring_ej = !iRingEmpty && (iRingDat[WIDTH-1 -: ID_W] == NODE);
        ring_lk = !iRingEmpty && (iRingDat[WIDTH-1 -: ID_W] != NODE);
        loc_ej  = !iLocEmpty  && (iLocDat[WIDTH-1 -: ID_W] == NODE);
        loc_lk  = !iLocEmpty  && (iLocDat[WIDTH-1 -: ID_W] != NODE);

        ej_free = !ej_vld_q || iEjRdy;
        crdt_ok = (crdt_q != '0);
        starved = (starve_q == STARVE_LIM);

        // Ring traffic owns the eject register; local only ejects when ring has nothing for it.
        ring_ej_gnt = ring_ej && ej_free;
        loc_ej_gnt  = loc_ej && ej_free && !ring_ej;
        ring_lk_gnt = crdt_ok && ring_lk && !(loc_lk && starved);
        loc_lk_gnt  = crdt_ok && loc_lk && (!ring_lk || starved);
        link_gnt    = ring_lk_gnt || loc_lk_gnt;

        oRingRdEn = !rst && (ring_ej_gnt || ring_lk_gnt);
        oLocRdEn  = !rst && (loc_ej_gnt || loc_lk_gnt);
    end

    always_comb begin
        link_vld_d = link_gnt;
        link_dat_d = link_dat_q;
        ej_vld_d   = ej_vld_q;
        ej_dat_d   = ej_dat_q;
        crdt_d     = crdt_q;
        crdt_err_d = crdt_err_q;
        starve_d   = starve_q;

        if (ring_lk_gnt) begin
            link_dat_d = iRingDat;
        end else if (loc_lk_gnt) begin
            link_dat_d = iLocDat;
        end

        if (ring_ej_gnt) begin
            ej_vld_d = 1'b1;
            ej_dat_d = iRingDat;
        end else if (loc_ej_gnt) begin
            ej_vld_d = 1'b1;
            ej_dat_d = iLocDat;
        end else if (iEjRdy) begin
            ej_vld_d = 1'b0;
        end

        if (loc_lk_gnt) begin
            starve_d = '0;
        end else if (ring_lk_gnt && loc_lk && !starved) begin
            starve_d = starve_q + SW'(1);
        end

        // A credit returned while already full is a downstream protocol violation.
        if (iLinkCrdt && (crdt_q == CRDT_MAX)) begin
            crdt_err_d = 1'b1;
        end
        case ({link_gnt, iLinkCrdt})
            2'b10:   crdt_d = crdt_q - CW'(1);
            2'b01:   if (crdt_q != CRDT_MAX) crdt_d = crdt_q + CW'(1);
            default: crdt_d = crdt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_vld_q <= 1'b0;
            link_dat_q <= '0;
            ej_vld_q   <= 1'b0;
            ej_dat_q   <= '0;
            crdt_q     <= CRDT_MAX;
            crdt_err_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            link_vld_q <= link_vld_d;
            link_dat_q <= link_dat_d;
            ej_vld_q   <= ej_vld_d;
            ej_dat_q   <= ej_dat_d;
            crdt_q     <= crdt_d;
            crdt_err_q <= crdt_err_d;
            starve_q   <= starve_d;
        end
    end

    assign oLinkVld = link_vld_q;
    assign oLinkDat = link_dat_q;
    assign oEjVld   = ej_vld_q;
    assign oEjDat   = ej_dat_q;
    assign oCrdt    = crdt_q;
    assign oCrdtErr = crdt_err_q;

endmodule
